// File: rtl/count_down4_if.sv
// Control and status bundle for the count_down4 loadable down-counter.
// The controller drives load/step controls; the counter returns count, busy, done and its FSM state.
interface count_down4_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             cntby2;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output load, load_val, enable, cntby2, auto_reload,
    input  count, busy, done, state
  );

  modport slave (
    input  load, load_val, enable, cntby2, auto_reload,
    output count, busy, done, state
  );
endinterface

// File: rtl/count_down4.sv
// Loadable saturating down-counter with a step of 1 or 2 and optional auto-reload.
// A three-state FSM (IDLE/RUN/DONE) drives registered busy and a one-cycle done pulse.
module count_down4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         nReset,
  count_down4_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, done_q;
  logic [WIDTH:0]   step;

  // One bit wider than count so the saturation compare also works when WIDTH is 1.
  assign step = {{(WIDTH-1){1'b0}}, bus.cntby2, ~bus.cntby2};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (bus.enable) begin
            if ({1'b0, count_q} > step) begin
              count_d = count_q - step[WIDTH-1:0];
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.auto_reload && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = RUN;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
        default: begin
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // busy/done are registered from the next state so they line up with the count they describe.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_count_down4.sv
// Self-checking bench for count_down4: per-cycle stimulus and expected {count,busy,done}
// are queued together, then applied and compared one clock at a time.
module tb_count_down4;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;

  logic clk;
  logic nReset;

  count_down4_if #(.WIDTH(WIDTH)) bus ();

  count_down4 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus word: {load, load_val, enable, cntby2, auto_reload}
  logic [WIDTH+3:0] stim_q[$];
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    exp_v;
  logic [EW-1:0]    got_v;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [WIDTH+3:0] s);
    bus.load        = s[WIDTH+3];
    bus.load_val    = s[WIDTH+2:3];
    bus.enable      = s[2];
    bus.cntby2      = s[1];
    bus.auto_reload = s[0];
  endtask

  task automatic add(input logic ld, input logic [WIDTH-1:0] lv, input logic en,
                     input logic c2, input logic ar,
                     input logic [WIDTH-1:0] c, input logic b, input logic d);
    stim_q.push_back({ld, lv, en, c2, ar});
    exp_q.push_back({c, b, d});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply('0);
    nReset = 1'b0;
    #1;
    checks++;
    got_v = {bus.count, bus.busy, bus.done};
    if (got_v !== {EW{1'b0}}) begin
      errors++;
      $display("FAIL reset_initial: count/busy/done got %0d/%b/%b expected 0/0/0", got_v[EW-1:2], got_v[1], got_v[0]);
    end
    // load is ignored while reset is held
    apply({1'b1, 4'd9, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    checks++;
    got_v = {bus.count, bus.busy, bus.done};
    if (got_v !== {EW{1'b0}}) begin
      errors++;
      $display("FAIL reset_hold_load: count/busy/done got %0d/%b/%b expected 0/0/0", got_v[EW-1:2], got_v[1], got_v[0]);
    end
    apply('0);
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 6; i++)
      add(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 4'd0, 1'b0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_basic();
    add(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL basic cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_step2();
    add(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    // mixed step: 6 -2-> 4 -1-> 3 -2-> 1 -1-> 0
    add(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL step2 cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_auto_reload();
    add(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    // auto_reload low during RUN is ignored; only the DONE-exit edge matters
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL auto_reload cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_load_priority();
    add(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
    add(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    // load during DONE wins over auto-reload of the old value
    add(1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL load_priority cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    add(1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL async_pre cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
    // drop reset between edges and look before any further clock edge
    #2 nReset = 1'b0;
    #1;
    got_v = {bus.count, bus.busy, bus.done};
    checks++;
    if (got_v !== {EW{1'b0}}) begin
      errors++;
      $display("FAIL async_mid_count: count/busy/done got %0d/%b/%b expected 0/0/0", got_v[EW-1:2], got_v[1], got_v[0]);
    end
    @(negedge clk);
    nReset = 1'b1;
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL async_post cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
    // reset during the DONE cycle kills the pulse and the pending reload
    #2 nReset = 1'b0;
    #1;
    got_v = {bus.count, bus.busy, bus.done};
    checks++;
    if (got_v !== {EW{1'b0}}) begin
      errors++;
      $display("FAIL async_in_done: count/busy/done got %0d/%b/%b expected 0/0/0", got_v[EW-1:2], got_v[1], got_v[0]);
    end
    @(negedge clk);
    nReset = 1'b1;
    apply({1'b0, 4'd0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    got_v = {bus.count, bus.busy, bus.done};
    checks++;
    if (got_v !== {EW{1'b0}}) begin
      errors++;
      $display("FAIL async_no_reload: count/busy/done got %0d/%b/%b expected 0/0/0", got_v[EW-1:2], got_v[1], got_v[0]);
    end
  endtask

  task automatic test_zero_max();
    add(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    add(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
    for (int v = 13; v >= 1; v -= 2)
      add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'(v), 1'b1, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {bus.count, bus.busy, bus.done};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL zero_max cyc %0d: count/busy/done got %0d/%b/%b expected %0d/%b/%b",
                 n, got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_step2();
    test_auto_reload();
    test_load_priority();
    test_async_reset();
    test_zero_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
